// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the data-memory bus between the pipeline MEM stage and a DMA master.
// The CPU has priority; repeated DMA losses force a bounded DMA burst that stalls the pipeline.
module dmem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_valid,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    CPU_PRI,
    DMA_BURST
  } state_e;

  localparam logic [7:0] StarveLast = 8'(STARVE_LIMIT - 1);
  localparam logic [7:0] BeatLast   = 8'(BURST_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        dma_valid_q;
  logic [31:0] dma_rdata_q;

  logic cpu_acc;
  logic in_burst;
  logic own_cpu;
  logic own_dma;

  // While reset is high the burst state is ignored, so the bus already behaves as CPU_PRI.
  always_comb begin
    cpu_acc      = cpu_rd | cpu_wr;
    in_burst     = (state_q == DMA_BURST) && !reset;
    own_cpu      = 1'b0;
    own_dma      = 1'b0;
    cpu_stall    = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    beat_cnt_d   = beat_cnt_q;

    if (!in_burst) begin
      state_d = CPU_PRI;
      if (cpu_acc) begin
        own_cpu = 1'b1;
        if (dma_req) begin
          if (starve_cnt_q == StarveLast) begin
            state_d      = DMA_BURST;
            starve_cnt_d = 8'd0;
            beat_cnt_d   = 8'd0;
          end else begin
            starve_cnt_d = starve_cnt_q + 8'd1;
          end
        end else begin
          starve_cnt_d = 8'd0;
        end
      end else begin
        own_dma      = dma_req;
        starve_cnt_d = 8'd0;
      end
    end else begin
      starve_cnt_d = 8'd0;
      if (dma_req) begin
        own_dma    = 1'b1;
        cpu_stall  = cpu_acc;
        beat_cnt_d = beat_cnt_q + 8'd1;
        if (beat_cnt_q == BeatLast) begin
          state_d    = CPU_PRI;
          beat_cnt_d = 8'd0;
        end
      end else begin
        // DMA released the bus early: the CPU access goes ahead in this same cycle.
        state_d    = CPU_PRI;
        own_cpu    = cpu_acc;
        beat_cnt_d = 8'd0;
      end
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (own_cpu) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (own_dma) begin
      mem_rd    = !dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CPU_PRI;
      starve_cnt_q <= 8'd0;
      beat_cnt_q   <= 8'd0;
      dma_valid_q  <= 1'b0;
      dma_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      dma_valid_q  <= own_dma && !dma_wr;
      if (own_dma && !dma_wr) begin
        dma_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dma_gnt   = own_dma;
  assign dma_valid = dma_valid_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a driver queues the expected response of every cycle
// and an independent monitor pops and compares it against the DUT on the falling edge.
module tb_dmem_bus_arbiter;

  typedef enum int {OWN_NONE, OWN_CPU, OWN_DMA} own_e;

  typedef struct {
    int          step;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        gnt;
    logic        valid;
    logic [31:0] dmaData;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_valid;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        rstS, cpuRdS, cpuWrS, dmaReqS, dmaWrS;
  logic [31:0] cpuAddrS, cpuDataS, dmaAddrS, dmaDataS, memRdataS;
  logic        lastValid;
  logic [31:0] lastData;
  int          stepNo;
  int          total;
  int          bad;
  exp_t        expQ[$];

  dmem_bus_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int step, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e.step, "mem_rd",    32'(mem_rd),    32'(e.rd));
      checkOutput(e.step, "mem_wr",    32'(mem_wr),    32'(e.wr));
      checkOutput(e.step, "mem_addr",  mem_addr,       e.addr);
      checkOutput(e.step, "mem_wdata", mem_wdata,      e.wdata);
      checkOutput(e.step, "cpu_rdata", cpu_rdata,      e.rdata);
      checkOutput(e.step, "cpu_stall", 32'(cpu_stall), 32'(e.stall));
      checkOutput(e.step, "dma_gnt",   32'(dma_gnt),   32'(e.gnt));
      checkOutput(e.step, "dma_valid", 32'(dma_valid), 32'(e.valid));
      checkOutput(e.step, "dma_rdata", dma_rdata,      e.dmaData);
    end
  end

  task automatic setCpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpuRdS = rd; cpuWrS = wr; cpuAddrS = a; cpuDataS = d;
  endtask

  task automatic setDma(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
    dmaReqS = rq; dmaWrS = wr; dmaAddrS = a; dmaDataS = d;
  endtask

  // Drives one cycle of staged inputs and queues the response the bench expects for it.
  task automatic applyStimulus(input own_e own, input logic stall, input logic [31:0] memData);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rstS;
    cpu_rd    = cpuRdS;   cpu_wr    = cpuWrS;
    cpu_addr  = cpuAddrS; cpu_wdata = cpuDataS;
    dma_req   = dmaReqS;  dma_wr    = dmaWrS;
    dma_addr  = dmaAddrS; dma_wdata = dmaDataS;
    mem_rdata = memData;
    e.step    = stepNo;
    e.rd      = 1'b0; e.wr = 1'b0; e.addr = 32'd0; e.wdata = 32'd0;
    if (own == OWN_CPU) begin
      e.rd = cpuRdS; e.wr = cpuWrS; e.addr = cpuAddrS; e.wdata = cpuDataS;
    end else if (own == OWN_DMA) begin
      e.rd = !dmaWrS; e.wr = dmaWrS; e.addr = dmaAddrS; e.wdata = dmaDataS;
    end
    e.rdata   = memData;
    e.stall   = stall;
    e.gnt     = (own == OWN_DMA);
    e.valid   = lastValid;
    e.dmaData = lastData;
    expQ.push_back(e);
    if (rstS) begin
      lastValid = 1'b0;
      lastData  = 32'd0;
    end else if (own == OWN_DMA && !dmaWrS) begin
      lastValid = 1'b1;
      lastData  = memData;
    end else begin
      lastValid = 1'b0;
    end
    stepNo++;
  endtask

  task automatic runCycles(input int n, input own_e own, input logic stall, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      applyStimulus(own, stall, base + 32'(k));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total = 0; bad = 0; stepNo = 0;
    lastValid = 1'b0; lastData = 32'd0;
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    mem_rdata = 32'd0;
    rstS = 1'b1;
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    setDma(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);

    // Reset state, then a plain CPU write and an opportunistic DMA read.
    runCycles(1, OWN_NONE, 1'b0, 32'd0);
    rstS = 1'b0;
    setCpu(1'b0, 1'b1, 32'h10, 32'hA5);
    runCycles(1, OWN_CPU, 1'b0, 32'hDEAD_0000);
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    setDma(1'b1, 1'b0, 32'h20, 32'd0);
    runCycles(1, OWN_DMA, 1'b0, 32'h1234);
    setDma(1'b0, 1'b0, 32'd0, 32'd0);
    runCycles(1, OWN_NONE, 1'b0, 32'd0);

    // Continuous contention: 4 CPU wins, 8 forced beats, 4 CPU wins.
    setCpu(1'b1, 1'b0, 32'h100, 32'd0);
    setDma(1'b1, 1'b0, 32'h200, 32'd0);
    runCycles(4, OWN_CPU, 1'b0, 32'hA000);
    runCycles(8, OWN_DMA, 1'b1, 32'hB000);
    runCycles(4, OWN_CPU, 1'b0, 32'hC000);

    // Burst cut short after 3 beats; starvation count must restart from zero.
    runCycles(3, OWN_DMA, 1'b1, 32'hD000);
    setDma(1'b0, 1'b0, 32'h200, 32'd0);
    runCycles(1, OWN_CPU, 1'b0, 32'hE000);
    setDma(1'b1, 1'b0, 32'h200, 32'd0);
    runCycles(4, OWN_CPU, 1'b0, 32'hF000);

    // Reset lands on beat 5 of a burst.
    runCycles(4, OWN_DMA, 1'b1, 32'h9000);
    rstS = 1'b1;
    runCycles(1, OWN_CPU, 1'b0, 32'h8000);
    rstS = 1'b0;
    setDma(1'b0, 1'b0, 32'd0, 32'd0);
    runCycles(1, OWN_CPU, 1'b0, 32'h7000);

    // Same-address writes: CPU wins, DMA write retried next cycle.
    setCpu(1'b0, 1'b1, 32'h40, 32'h1);
    setDma(1'b1, 1'b1, 32'h40, 32'h2);
    runCycles(1, OWN_CPU, 1'b0, 32'd0);
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    runCycles(1, OWN_DMA, 1'b0, 32'd0);
    setDma(1'b0, 1'b0, 32'd0, 32'd0);
    runCycles(1, OWN_NONE, 1'b0, 32'd0);

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
